// File: rtl/adder_pkg.sv
// Shared definitions for the byte accumulator: data width and FSM state encoding.
package adder_pkg;

    localparam int DATA_W = 8;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } adder_state_e;

endpackage

// File: rtl/adder.sv
// Plain combinational DATA_W-bit adder; the sum wraps and carry-out is derived by the caller.
module adder
    import adder_pkg::*;
(
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    output logic [DATA_W-1:0] sum
);

    assign sum = a_in + b_in;

endmodule

// File: rtl/adder_accum.sv
// Frame accumulator: sums operand bytes until in_last, then holds the result for the consumer.
// Options: USE_POWER_PINS adds vdd/vss; ADDER_ACCUM_SAT_EN clamps acc to 8'hFF on carry-out.
module adder_accum
    import adder_pkg::*;
#(
    parameter int CNT_W = 4
) (
`ifdef USE_POWER_PINS
    inout  wire               vdd,
    inout  wire               vss,
`endif
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_ovf,
    output logic [CNT_W-1:0]  out_cnt,
    output adder_state_e      state_dbg
);

    // Handshakes: a beat transfers on a rising edge where valid and ready are both high;
    // in_ready depends only on state, never on in_valid, and out_* stay frozen while out_valid waits.

    adder_state_e      state;
    adder_state_e      state_next;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] acc_next;
    logic [DATA_W-1:0] sum;
    logic              ovf;
    logic [CNT_W-1:0]  cnt;
    logic              carry;
    logic              accept;
    logic              drain;

    adder u_adder (
        .a_in (acc),
        .b_in (in_data),
        .sum  (sum)
    );

    assign carry = (acc[DATA_W-1] & in_data[DATA_W-1])
                 | ((acc[DATA_W-1] ^ in_data[DATA_W-1]) & ~sum[DATA_W-1]);

    assign accept = in_valid && (state == ACCUM);
    assign drain  = out_ready && (state == HOLD);

`ifdef ADDER_ACCUM_SAT_EN
    assign acc_next = carry ? {DATA_W{1'b1}} : sum;
`else
    assign acc_next = sum;
`endif

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= ACCUM;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ACCUM:   if (accept && in_last) state_next = HOLD;
            HOLD:    if (out_ready)         state_next = ACCUM;
            default:                        state_next = ACCUM;
        endcase
    end

    // Reset gates the outputs directly so they read idle even before the first clock edge.
    always_comb begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        out_data  = '0;
        out_ovf   = 1'b0;
        out_cnt   = '0;
        if (!wb_rst_i) begin
            in_ready  = (state == ACCUM);
            out_valid = (state == HOLD);
            out_data  = acc;
            out_ovf   = ovf;
            out_cnt   = cnt;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || drain) begin
            acc <= '0;
            ovf <= 1'b0;
            cnt <= '0;
        end else if (accept) begin
            acc <= acc_next;
            ovf <= ovf | carry;
            if (cnt != {CNT_W{1'b1}}) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_adder_accum.sv
// Self-checking bench for adder_accum: vector table, hand-written corner sequences, random frames.
module tb_adder_accum;
    import adder_pkg::*;

    localparam int CW = 4;
`ifdef ADDER_ACCUM_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [7:0]    out_data;
    logic          out_ovf;
    logic [CW-1:0] out_cnt;
    adder_state_e  state_dbg;
`ifdef USE_POWER_PINS
    wire           vdd;
    wire           vss;
`endif

    int total = 0;
    int bad   = 0;
    logic [7:0] frame_q[$];

    typedef struct {
        string      name;
        int         len;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        bit         gap;
        logic [7:0] exp_d;
        bit         exp_o;
        logic [3:0] exp_c;
    } vec_t;

    vec_t tbl[6];

    adder_accum #(.CNT_W(CW)) dut (
`ifdef USE_POWER_PINS
        .vdd       (vdd),
        .vss       (vss),
`endif
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .out_cnt   (out_cnt),
        .state_dbg (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: running sum of the frame, carry whenever a step exceeds 255.
    task automatic model(output logic [7:0] d, output bit o, output logic [3:0] c);
        int a;
        int s;
        a = 0;
        o = 1'b0;
        foreach (frame_q[i]) begin
            s = a + int'(frame_q[i]);
            if (s > 255) begin
                o = 1'b1;
                a = SAT ? 255 : s - 256;
            end else begin
                a = s;
            end
        end
        d = a[7:0];
        c = (frame_q.size() > 15) ? 4'd15 : 4'(frame_q.size());
    endtask

    task automatic wait_ready(input string name);
        int budget;
        budget = 0;
        while (in_ready !== 1'b1 && budget < 50) begin
            tick();
            budget++;
        end
        if (in_ready !== 1'b1) chk({name, " ready_timeout"}, 32'(in_ready), 32'd1);
    endtask

    task automatic run_frame(input string name, input bit gap, input int hold,
                             input logic [7:0] ed, input bit eo, input logic [3:0] ec);
        int n;
        n = frame_q.size();
        out_ready = (hold == 0);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = frame_q[i];
            in_last  = (i == n - 1);
            wait_ready(name);
            tick();
            in_valid = 1'b0;
            in_last  = 1'b0;
            in_data  = 8'($urandom);
            if (i < n - 1) begin
                chk({name, " mid_valid"}, 32'(out_valid), 32'd0);
                if (gap) begin
                    tick();
                    chk({name, " idle_valid"}, 32'(out_valid), 32'd0);
                end
            end
        end
        chk({name, " out_valid"}, 32'(out_valid), 32'd1);
        chk({name, " out_data"}, 32'(out_data), 32'(ed));
        chk({name, " out_ovf"}, 32'(out_ovf), 32'(eo));
        chk({name, " out_cnt"}, 32'(out_cnt), 32'(ec));
        chk({name, " state_hold"}, 32'(state_dbg), 32'(HOLD));
        for (int k = 0; k < hold; k++) begin
            tick();
            chk({name, " hold_valid"}, 32'(out_valid), 32'd1);
            chk({name, " hold_data"}, 32'(out_data), 32'(ed));
            chk({name, " hold_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        chk({name, " drain_valid"}, 32'(out_valid), 32'd0);
        chk({name, " drain_ready"}, 32'(in_ready), 32'd1);
        chk({name, " drain_cnt"}, 32'(out_cnt), 32'd0);
    endtask

    initial begin
        logic [7:0] ed;
        bit         eo;
        logic [3:0] ec;
        int         len;

        tbl[0] = '{"basic3",  3, 8'h10, 8'h20, 8'h03, 1'b0, 8'h33, 1'b0, 4'd3};
        tbl[1] = '{"carry2",  2, 8'hF0, 8'h20, 8'h00, 1'b0, SAT ? 8'hFF : 8'h10, 1'b1, 4'd2};
        tbl[2] = '{"single",  1, 8'h5A, 8'h00, 8'h00, 1'b0, 8'h5A, 1'b0, 4'd1};
        tbl[3] = '{"gapped",  3, 8'h01, 8'h02, 8'h04, 1'b1, 8'h07, 1'b0, 4'd3};
        tbl[4] = '{"wrap3",   3, 8'h80, 8'h80, 8'h01, 1'b0, SAT ? 8'hFF : 8'h01, 1'b1, 4'd3};
        tbl[5] = '{"ffzero",  3, 8'hFF, 8'h00, 8'h00, 1'b0, 8'hFF, 1'b0, 4'd3};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_last   = 1'b0;
        out_ready = 1'b1;

        #1;
        chk("rst in_ready", 32'(in_ready), 32'd1);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst out_data", 32'(out_data), 32'd0);
        chk("rst out_ovf", 32'(out_ovf), 32'd0);
        chk("rst out_cnt", 32'(out_cnt), 32'd0);
        repeat (3) tick();
        rst = 1'b0;
        chk("post_rst state", 32'(state_dbg), 32'(ACCUM));
        chk("post_rst out_valid", 32'(out_valid), 32'd0);

        foreach (tbl[t]) begin
            frame_q.delete();
            frame_q.push_back(tbl[t].b0);
            if (tbl[t].len > 1) frame_q.push_back(tbl[t].b1);
            if (tbl[t].len > 2) frame_q.push_back(tbl[t].b2);
            run_frame(tbl[t].name, tbl[t].gap, 0, tbl[t].exp_d, tbl[t].exp_o, tbl[t].exp_c);
        end

        // Counter saturates while the sum keeps growing.
        frame_q.delete();
        repeat (20) frame_q.push_back(8'h01);
        run_frame("cnt_sat", 1'b0, 0, 8'h14, 1'b0, 4'd15);

        // Backpressure with a pending byte: nothing consumed until release, then a fresh frame.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h77;
        in_last   = 1'b1;
        tick();
        in_data = 8'h99;
        for (int k = 0; k < 5; k++) begin
            chk("bp out_valid", 32'(out_valid), 32'd1);
            chk("bp in_ready", 32'(in_ready), 32'd0);
            chk("bp out_data", 32'(out_data), 32'h77);
            chk("bp out_cnt", 32'(out_cnt), 32'd1);
            tick();
        end
        out_ready = 1'b1;
        tick();
        chk("bp release valid", 32'(out_valid), 32'd0);
        chk("bp release ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("bp fresh data", 32'(out_data), 32'h99);
        chk("bp fresh cnt", 32'(out_cnt), 32'd1);
        chk("bp fresh ovf", 32'(out_ovf), 32'd0);
        tick();
        chk("bp fresh drain", 32'(out_valid), 32'd0);

        // Reset mid-frame discards the partial sum.
        in_valid = 1'b1;
        in_data  = 8'h40;
        in_last  = 1'b0;
        repeat (2) tick();
        in_valid = 1'b0;
        chk("abort partial cnt", 32'(out_cnt), 32'd2);
        chk("abort no valid", 32'(out_valid), 32'd0);
        rst = 1'b1;
        #1;
        chk("abort rst cnt", 32'(out_cnt), 32'd0);
        chk("abort rst ready", 32'(in_ready), 32'd1);
        repeat (2) tick();
        rst = 1'b0;
        chk("abort post valid", 32'(out_valid), 32'd0);
        frame_q.delete();
        frame_q.push_back(8'h05);
        run_frame("after_abort", 1'b0, 0, 8'h05, 1'b0, 4'd1);

        // Reset while a result is pending also drops it.
        frame_q.delete();
        frame_q.push_back(8'h33);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h33;
        in_last   = 1'b1;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("hold_rst pending", 32'(out_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("hold_rst dropped", 32'(out_valid), 32'd0);
        chk("hold_rst state", 32'(state_dbg), 32'(ACCUM));
        out_ready = 1'b1;

        for (int r = 0; r < 40; r++) begin
            frame_q.delete();
            len = $urandom_range(1, 20);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 1) == 0) frame_q.push_back(8'($urandom_range(0, 15)));
                else                           frame_q.push_back(8'($urandom));
            end
            model(ed, eo, ec);
            run_frame($sformatf("rand%0d", r), 1'($urandom_range(0, 1)), $urandom_range(0, 3), ed, eo, ec);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adder_accum.md
ADDER_ACCUM -- requirements
Module: adder_accum

Interface
REQ-001 SHALL have parameter: CNT_W, default 4, width of term counter out_cnt.
REQ-002 SHALL have port: wb_clk_i  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: wb_rst_i  input  1  reset; synchronous, active-high.
REQ-004 SHALL have ports: vdd, vss  inout  1 each  supply and ground; present only when USE_POWER_PINS is defined.
REQ-005 SHALL have port: in_valid  input  1  operand byte valid.
REQ-006 SHALL have port: in_ready  output  1  block can accept an operand byte.
REQ-007 SHALL have port: in_data  input  8  unsigned operand byte.
REQ-008 SHALL have port: in_last  input  1  final byte of the current frame; qualified by the in_valid and in_ready handshake.
REQ-009 SHALL have port: out_valid  output  1  frame result valid.
REQ-010 SHALL have port: out_ready  input  1  consumer accepts the result.
REQ-011 SHALL have port: out_data  output  8  accumulated frame sum.
REQ-012 SHALL have port: out_ovf  output  1  sticky flag; carry-out occurred somewhere in the frame.
REQ-013 SHALL have port: out_cnt  output  CNT_W  count of accepted bytes in the frame; saturates at 2^CNT_W-1.

Function
REQ-014 SHALL implement a two-state FSM: ACCUM and HOLD.
REQ-015 In ACCUM, SHALL drive in_ready=1 and out_valid=0.
REQ-016 In HOLD, SHALL drive in_ready=0 and out_valid=1.
REQ-017 SHALL drive the adder inputs as a_in = acc register and b_in = in_data; the adder is combinational.
REQ-018 SHALL compute carry-out combinationally as (acc[7]&in_data[7]) | ((acc[7]^in_data[7]) & ~sum[7]).
REQ-019 On each accepted beat (in_valid & in_ready), SHALL update acc from sum and increment cnt, with saturation per REQ-013.
REQ-020 On an accepted beat with carry-out=1, SHALL set ovf, and ovf SHALL stay set until the frame ends.
REQ-021 On an accepted beat with in_last=1, SHALL move ACCUM->HOLD.
REQ-022 out_valid SHALL assert on the cycle after the last byte is accepted (latency of 1 cycle).
REQ-023 out_data, out_ovf and out_cnt SHALL equal acc, ovf and cnt, and SHALL stay stable throughout HOLD.
REQ-024 In HOLD, when out_ready=1, SHALL move HOLD->ACCUM.
REQ-025 On the HOLD->ACCUM transition, SHALL clear acc, ovf and cnt to 0, so out_valid deasserts and in_ready asserts on the next cycle.
REQ-026 In HOLD with out_ready=0, SHALL hold indefinitely; input bytes are not accepted (backpressure).
REQ-027 A single-byte frame (in_last on the first beat) SHALL produce out_data=in_data, out_cnt=1, out_ovf=0.
REQ-028 in_valid=0 in ACCUM SHALL leave all state unchanged.
REQ-029 When counting past 2^CNT_W-1, cnt SHALL hold at that maximum; acc SHALL continue to update.

Reset
REQ-030 While wb_rst_i=1 at a clock edge, SHALL set state=ACCUM, acc=0, ovf=0, cnt=0.
REQ-031 While in reset, outputs SHALL be in_ready=1, out_valid=0, out_data=0, out_ovf=0, out_cnt=0.
REQ-032 Reset asserted mid-frame or in HOLD SHALL discard the partial or pending result with no output beat.

Configuration
REQ-033 With ADDER_ACCUM_SAT_EN defined, an accepted beat with carry-out=1 SHALL load acc=8'hFF.
REQ-034 With ADDER_ACCUM_SAT_EN defined, acc SHALL then stay 8'hFF for the rest of the frame, since every further nonzero add carries.
REQ-035 Without ADDER_ACCUM_SAT_EN, acc SHALL wrap modulo 256.
REQ-036 out_ovf behaviour SHALL be identical with and without ADDER_ACCUM_SAT_EN.

Structure
REQ-037 A shared package adder_pkg SHALL hold the data width constant DATA_W=8 and the FSM state enum (ACCUM, HOLD).
REQ-038 SHALL instantiate the existing 8-bit adder as the single sub-module, named adder, providing the sum; no other sub-modules.
REQ-039 Carry-out, saturation and FSM logic SHALL be local to adder_accum.

Verification
REQ-040 Frame 0x10, 0x20, 0x03(last), out_ready=1 -> out_data=0x33, out_ovf=0, out_cnt=3; out_valid exactly 1 cycle, 1 cycle after the last beat.
REQ-041 Frame 0xF0, 0x20(last) -> SAT_EN off: out_data=0x10, out_ovf=1; SAT_EN on: out_data=0xFF, out_ovf=1.
REQ-042 Result pending with out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0 and out_data stable for all 5 cycles; no byte consumed; first byte after release lands in a fresh frame (acc from 0).
REQ-043 CNT_W=4, 20 bytes of 0x01 with in_last on the 20th -> out_cnt=15, out_data=0x14, out_ovf=0.
REQ-044 Reset after 2 bytes (0x40, 0x40), then frame 0x05(last) -> out_data=0x05, out_cnt=1; no output beat for the aborted frame.
REQ-045 in_valid toggling every other cycle over frame 0x01, 0x02, 0x04(last) -> out_data=0x07, out_cnt=3; idle cycles leave acc unchanged.
